conv_encoder_tx: RTL

- Transmit-side K=7 convolutional encoder, generators g0=133, g1=171 (octal). It is the encoding counterpart of the receive Viterbi decoder.
- Accepts payload bytes over a valid/ready handshake and serialises each byte LSB first.
- Appends K-1 zero tail bits and emits one coded (A,B) pair per cycle. Each pair carries 802.11 puncture keep flags for rate 1/2, 2/3 or 3/4.
- Sits between the TX byte source and the interleaver/mapper.

---
 rtl/tx_coding_pkg.sv | 50 +++++
 rtl/conv_encoder_tx_core.sv | 44 ++++
 rtl/conv_encoder_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tx_coding_pkg.sv
// Shared TX coding definitions: rates, encoder FSM states, puncture keep tables
// and the default K=7 generator pair shared with the receive-side decoder.
package tx_coding_pkg;

    localparam int K        = 7;
    localparam int TAIL_LEN = K - 1;

    localparam logic [K-1:0] G0_DEFAULT = 7'o133;
    localparam logic [K-1:0] G1_DEFAULT = 7'o171;

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_DONE
    } enc_state_t;

    // Returns {keep_a, keep_b}; code 2'b11 and any unknown rate fall back to 1/2.
    function automatic logic [1:0] keep_lookup(input logic [1:0] rate, input logic [1:0] phase);
        logic [1:0] keep;
        keep = 2'b11;
        case (rate)
            RATE_2_3: keep = (phase == 2'd0) ? 2'b11 : 2'b10;
            RATE_3_4: begin
                case (phase)
                    2'd0:    keep = 2'b11;
                    2'd1:    keep = 2'b10;
                    default: keep = 2'b01;
                endcase
            end
            default:  keep = 2'b11;
        endcase
        return keep;
    endfunction

    function automatic logic [1:0] phase_next(input logic [1:0] rate, input logic [1:0] phase);
        logic [1:0] last_phase;
        case (rate)
            RATE_2_3: last_phase = 2'd1;
            RATE_3_4: last_phase = 2'd2;
            default:  last_phase = 2'd0;
        endcase
        return (phase == last_phase) ? 2'd0 : phase + 2'd1;
    endfunction

endpackage

// File: rtl/conv_encoder_tx_core.sv
// Convolutional encoder core: combinational A/B from the current bit and shift state.
// Latency: outputs are combinational; state advances one bit per adv strobe.
// Backpressure: none internally, the caller only strobes adv when a pair is taken.
module conv_enc_core
    import tx_coding_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    input  logic bit_in,
    output logic enc_a,
    output logic enc_b
);

    logic [K-2:0] s;
    logic [K-1:0] taps;

    // Generator MSB taps the incoming bit, lower bits walk back through history s[0..K-2].
    always_comb begin
        taps        = '0;
        taps[K-1]   = bit_in;
        for (int i = 0; i < K - 1; i++) begin
            taps[K-2-i] = s[i];
        end
    end

    assign enc_a = ^(taps & G0);
    assign enc_b = ^(taps & G1);

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else if (clr) begin
            s <= '0;
        end else if (adv) begin
            s <= {s[K-3:0], bit_in};
        end
    end

endmodule

// File: rtl/conv_encoder_tx.sv
// TX K=7 convolutional encoder: byte in, LSB-first coded (A,B) pairs plus tail and puncture flags.
// Latency: first pair is valid 2 cycles after the first byte handshake; back-to-back bytes stream gap-free.
// Backpressure: output register holds while vout & !vout_ready; din_ready drops while the holding byte is full.
module conv_encoder_tx
    import tx_coding_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       packet_start,
    input  logic [1:0] rate,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic       dout_a,
    output logic       dout_b,
    output logic       keep_a,
    output logic       keep_b,
    output logic       vout,
    input  logic       vout_ready,
    output logic       done
);

    enc_state_t state;
    logic [1:0] rate_q;
    logic [1:0] phase;
    logic [7:0] hold_dat;
    logic       hold_vld;
    logic       hold_last;
    logic [7:0] ser_dat;
    logic [3:0] ser_cnt;
    logic       ser_last;
    logic       last_taken;
    logic [2:0] tail_cnt;

    logic out_free;
    logic pair_go;
    logic din_fire;
    logic enc_bit;
    logic enc_a;
    logic enc_b;

    assign out_free  = !vout || vout_ready;
    assign pair_go   = out_free && (((state == ST_DATA) && (ser_cnt != 4'd0)) || (state == ST_TAIL));
    assign din_ready = (state == ST_DATA) && !hold_vld && !last_taken && !packet_start;
    assign din_fire  = din_valid && din_ready;
    assign enc_bit   = (state == ST_DATA) ? ser_dat[0] : 1'b0;

    // The core state advances when a pair is committed to the output register,
    // which keeps the emitted sequence identical to advancing on downstream accept.
    conv_enc_core u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (packet_start),
        .adv    (pair_go),
        .bit_in (enc_bit),
        .enc_a  (enc_a),
        .enc_b  (enc_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rate_q     <= RATE_1_2;
            phase      <= 2'd0;
            hold_dat   <= '0;
            hold_vld   <= 1'b0;
            hold_last  <= 1'b0;
            ser_dat    <= '0;
            ser_cnt    <= '0;
            ser_last   <= 1'b0;
            last_taken <= 1'b0;
            tail_cnt   <= '0;
            vout       <= 1'b0;
            dout_a     <= 1'b0;
            dout_b     <= 1'b0;
            keep_a     <= 1'b0;
            keep_b     <= 1'b0;
            done       <= 1'b0;
        end else if (packet_start) begin
            // Start or abort: flush everything in flight and restart from a clean trellis.
            state      <= ST_DATA;
            rate_q     <= rate;
            phase      <= 2'd0;
            hold_vld   <= 1'b0;
            hold_last  <= 1'b0;
            ser_cnt    <= '0;
            ser_last   <= 1'b0;
            last_taken <= 1'b0;
            tail_cnt   <= '0;
            vout       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (out_free) begin
                vout <= pair_go;
            end
            if (pair_go) begin
                dout_a           <= enc_a;
                dout_b           <= enc_b;
                {keep_a, keep_b} <= keep_lookup(rate_q, phase);
                phase            <= phase_next(rate_q, phase);
            end

            if (din_fire) begin
                hold_dat  <= din;
                hold_vld  <= 1'b1;
                hold_last <= din_last;
                if (din_last) begin
                    last_taken <= 1'b1;
                end
            end

            case (state)
                ST_DATA: begin
                    if (pair_go) begin
                        if (ser_cnt == 4'd1) begin
                            if (ser_last) begin
                                state    <= ST_TAIL;
                                tail_cnt <= '0;
                                ser_cnt  <= '0;
                            end else if (hold_vld) begin
                                // Refill on the 8th bit so consecutive bytes leave no bubble.
                                ser_dat  <= hold_dat;
                                ser_cnt  <= 4'd8;
                                ser_last <= hold_last;
                                hold_vld <= 1'b0;
                            end else begin
                                ser_cnt <= '0;
                            end
                        end else begin
                            ser_dat <= ser_dat >> 1;
                            ser_cnt <= ser_cnt - 4'd1;
                        end
                    end else if ((ser_cnt == 4'd0) && hold_vld) begin
                        ser_dat  <= hold_dat;
                        ser_cnt  <= 4'd8;
                        ser_last <= hold_last;
                        hold_vld <= 1'b0;
                    end
                end
                ST_TAIL: begin
                    if (pair_go) begin
                        tail_cnt <= tail_cnt + 3'd1;
                        if (tail_cnt == 3'(TAIL_LEN - 1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Last tail pair is still in the output register until downstream takes it.
                    if (vout && vout_ready) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
